// File: rtl/crc32_fifo_reader_if.sv
// Handshake bundle between the CRC32 FIFO reader, its byte FIFO and the register block.
// master: reader side (drives fifo_done, crc_out, busy, byte_count); slave: environment side.
interface crc32_fifo_reader_if;
  logic        en;
  logic        init;
  logic [7:0]  fifo_dout;
  logic [3:0]  fifo_count;
  logic        fifo_done;
  logic [31:0] crc_out;
  logic        busy;
  logic [15:0] byte_count;

  modport master (
    input  en,
    input  init,
    input  fifo_dout,
    input  fifo_count,
    output fifo_done,
    output crc_out,
    output busy,
    output byte_count
  );

  modport slave (
    output en,
    output init,
    output fifo_dout,
    output fifo_count,
    input  fifo_done,
    input  crc_out,
    input  busy,
    input  byte_count
  );
endinterface

// File: rtl/crc32_fifo_reader.sv
// Pops bytes from a FWFT FIFO and folds them bit-serially into a reflected CRC-32.
// Ports: clk, rst_n (sync, active low), bus (en/init/fifo_* in, fifo_done/crc_out/busy/byte_count out).
module crc32_fifo_reader #(
  parameter logic [31:0] POLY   = 32'hEDB88320,
  parameter logic [31:0] INIT   = 32'hFFFFFFFF,
  parameter logic [31:0] XOROUT = 32'hFFFFFFFF
) (
  input logic                 clk,
  input logic                 rst_n,
  crc32_fifo_reader_if.master bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] crc_reg;
  logic [7:0]  data_sr;
  logic [2:0]  bit_cnt;
  logic [15:0] cnt;
  logic        done_q;
  logic        fb;

  assign fb = crc_reg[0] ^ data_sr[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      crc_reg <= INIT;
      data_sr <= 8'h00;
      bit_cnt <= 3'd0;
      cnt     <= 16'd0;
      done_q  <= 1'b0;
    end else if (bus.init) begin
      // Any byte mid-shift was already popped and is dropped.
      state   <= IDLE;
      crc_reg <= INIT;
      cnt     <= 16'd0;
      done_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.en && bus.fifo_count != 4'd0) begin
            data_sr <= bus.fifo_dout;
            bit_cnt <= 3'd0;
            done_q  <= 1'b1;
            state   <= SHIFT;
          end else begin
            done_q  <= 1'b0;
          end
        end
        SHIFT: begin
          done_q  <= 1'b0;
          crc_reg <= (crc_reg >> 1) ^ (fb ? POLY : 32'h0);
          data_sr <= data_sr >> 1;
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            cnt   <= cnt + 16'd1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.fifo_done  = done_q;
  assign bus.busy       = (state != IDLE);
  assign bus.crc_out    = crc_reg ^ XOROUT;
  assign bus.byte_count = cnt;

endmodule

// File: tb/tb_crc32_fifo_reader.sv
// Self-checking bench for crc32_fifo_reader: byte-wise CRC model plus an 8-deep FWFT FIFO.
// Directed vectors with literal CRC pins; a per-cycle compare against the model.
module tb_crc32_fifo_reader;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  crc32_fifo_reader_if bus ();

  crc32_fifo_reader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // FWFT FIFO, 8 entries
  logic [7:0] fq[$];
  logic       wr_req;
  logic [7:0] wr_data;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.fifo_done) begin
      if (fq.size() == 0) begin
        errors++;
        $display("FAIL pop_empty: fifo_done with empty FIFO at cycle %0d", cyc);
      end else begin
        void'(fq.pop_front());
      end
    end
    if (wr_req && fq.size() < 8) fq.push_back(wr_data);
    bus.fifo_dout  <= (fq.size() != 0) ? fq[0] : 8'h00;
    bus.fifo_count <= 4'(fq.size());
  end

  // Behavioural model: a captured byte is folded whole, 8 edges after capture.
  logic [31:0] m_crc;
  logic [15:0] m_cnt;
  int          m_left;
  logic [7:0]  m_cur;
  logic        m_done;

  always @(posedge clk) begin
    m_done = 1'b0;
    if (!rst_n) begin
      m_crc  = 32'hFFFFFFFF;
      m_cnt  = 16'd0;
      m_left = 0;
    end else if (bus.init) begin
      m_crc  = 32'hFFFFFFFF;
      m_cnt  = 16'd0;
      m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_crc = crc_byte(m_crc, m_cur);
        m_cnt = m_cnt + 16'd1;
      end
    end else if (bus.en && bus.fifo_count != 4'd0) begin
      m_cur  = bus.fifo_dout;
      m_left = 8;
      m_done = 1'b1;
    end
  end

  // Per-cycle compare and pulse monitor
  int   done_pulses = 0;
  int   first_rise = -1;
  int   last_fall = -1;
  logic prev_busy = 1'b0;
  logic prev_done = 1'b0;

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("busy", {31'h0, bus.busy}, {31'h0, (m_left != 0)});
      chk("fifo_done", {31'h0, bus.fifo_done}, {31'h0, m_done});
      chk("byte_count", {16'h0, bus.byte_count}, {16'h0, m_cnt});
      if (m_left == 0)
        chk("crc_out", bus.crc_out, m_crc ^ 32'hFFFFFFFF);
      if (bus.fifo_done && prev_done) begin
        errors++;
        $display("FAIL done_twice: fifo_done high two cycles running at %0d", cyc);
      end
      if (bus.fifo_done) done_pulses++;
      if (bus.busy && !prev_busy && first_rise < 0) first_rise = cyc;
      if (!bus.busy && prev_busy) last_fall = cyc;
      prev_busy = bus.busy;
      prev_done = bus.fifo_done;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    int n = 0;
    while (bus.fifo_count == 4'd8 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("push_timeout", 32'(n), 32'd0);
    wr_data = b;
    wr_req  = 1'b1;
    tick();
    wr_req  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bus.busy || bus.fifo_count != 4'd0) && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) chk("drain_timeout", 32'(n), 32'd0);
  endtask

  task automatic wait_pulses(input int target);
    int n = 0;
    while (done_pulses < target && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("pulse_timeout", 32'(done_pulses), 32'(target));
  endtask

  task automatic pulse_init();
    bus.init = 1'b1;
    tick();
    bus.init = 1'b0;
  endtask

  task automatic clear_marks();
    done_pulses = 0;
    first_rise  = -1;
    last_fall   = -1;
  endtask

  logic [7:0] s9 [9];
  int         p0;

  initial begin
    rst_n    = 1'b0;
    bus.en   = 1'b0;
    bus.init = 1'b0;
    wr_req   = 1'b0;
    wr_data  = 8'h00;
    bus.fifo_dout  = 8'h00;
    bus.fifo_count = 4'd0;
    tick();
    tick();
    rst_n = 1'b1;

    // idle, FIFO empty
    clear_marks();
    bus.en = 1'b1;
    repeat (20) tick();
    chk("idle_crc", bus.crc_out, 32'h00000000);
    chk("idle_busy", {31'h0, bus.busy}, 32'd0);
    chk("idle_pulses", 32'(done_pulses), 32'd0);

    // single 0x00
    clear_marks();
    push(8'h00);
    wait_idle();
    tick();
    chk("crc_00", bus.crc_out, 32'hD202EF8D);
    chk("cnt_00", {16'h0, bus.byte_count}, 32'd1);
    chk("pulses_00", 32'(done_pulses), 32'd1);
    chk("busy_span_00", 32'(last_fall - first_rise + 1), 32'd9);

    // single 0xFF from fresh CRC
    pulse_init();
    push(8'hFF);
    wait_idle();
    tick();
    chk("crc_ff", bus.crc_out, 32'hFF000000);
    chk("cnt_ff", {16'h0, bus.byte_count}, 32'd1);

    // "123456789" check value
    pulse_init();
    clear_marks();
    for (int i = 0; i < 9; i++) s9[i] = 8'h31 + 8'(i);
    for (int i = 0; i < 9; i++) push(s9[i]);
    wait_idle();
    tick();
    chk("crc_check", bus.crc_out, 32'hCBF43926);
    chk("cnt_check", {16'h0, bus.byte_count}, 32'd9);
    chk("pulses_check", 32'(done_pulses), 32'd9);
    chk("busy_span_check", 32'(last_fall - first_rise + 1), 32'd81);

    // init mid-shift of byte 2
    bus.en = 1'b0;
    pulse_init();
    push(8'hAA);
    push(8'hBB);
    push(8'h31);
    push(8'h32);
    clear_marks();
    bus.en = 1'b1;
    wait_pulses(2);
    tick();
    tick();
    tick();
    pulse_init();
    wait_idle();
    tick();
    chk("cnt_init", {16'h0, bus.byte_count}, 32'd2);
    chk("crc_init", bus.crc_out,
        crc_byte(crc_byte(32'hFFFFFFFF, 8'h31), 8'h32) ^ 32'hFFFFFFFF);

    // en held low with bytes queued
    bus.en = 1'b0;
    push(8'h10);
    push(8'h20);
    push(8'h30);
    clear_marks();
    repeat (20) tick();
    chk("en_low_count", {28'h0, bus.fifo_count}, 32'd3);
    chk("en_low_pulses", 32'(done_pulses), 32'd0);
    p0 = 0;
    bus.en = 1'b1;
    wait_pulses(1);
    bus.en = 1'b0;
    repeat (15) tick();
    chk("en_drop_count", {28'h0, bus.fifo_count}, 32'd2);
    chk("en_drop_busy", {31'h0, bus.busy}, 32'd0);
    chk("en_drop_bytes", {16'h0, bus.byte_count}, 32'd3);
    chk("en_drop_pulses", 32'(done_pulses), 32'd1);

    // reset mid-shift
    bus.en = 1'b1;
    wait_pulses(2);
    tick();
    tick();
    bus.en = 1'b0;
    rst_n  = 1'b0;
    tick();
    chk("rst_busy", {31'h0, bus.busy}, 32'd0);
    chk("rst_crc", bus.crc_out, 32'h00000000);
    chk("rst_cnt", {16'h0, bus.byte_count}, 32'd0);
    chk("rst_done", {31'h0, bus.fifo_done}, 32'd0);
    rst_n = 1'b1;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
